br_multiport: RTL and testbench
===============================

# br_multiport

Parametrised register bank, the next generation of the processor's two-read/one-write register file. It provides NR combinational read ports and two synchronous write ports (A and B), with a fixed collision rule and a registered collision flag. Register 0 can be hardwired to zero, and write-to-read forwarding can be compiled in. It sits between the decode stage (addresses) and the execute/writeback stages (operands, results).

## Interface
Parameters:
- WIDTH, 32, data width of every register.
- DEPTH, 32, number of registers; 2 ≤ DEPTH ≤ 2^AW.
- AW, 5, address width.
- NR, 2, number of read ports; 1 ≤ NR ≤ 8.
- ZERO_REG, 1
  - 1: register 0 always reads 0; writes to it are discarded.
  - 0: register 0 is ordinary.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ra  in  NR*AW  read addresses, packed; port k = ra[k*AW +: AW].
- rd  out  NR*WIDTH  read data, packed; port k = rd[k*WIDTH +: WIDTH].
- we_a  in  1  write enable, port A.
- wa_a  in  AW  write address, port A.
- wd_a  in  WIDTH  write data, port A.
- we_b  in  1  write enable, port B.
- wa_b  in  AW  write address, port B.
- wd_b  in  WIDTH  write data, port B.
- wr_conflict  out  1  registered flag: an A/B write collision occurred on the previous edge.

## Operation
- Storage is DEPTH registers of WIDTH bits. No memory macro is used, so asynchronous clear is possible.
- Reads are combinational. rd port k = reg[ra_k].
  - Reads 0 when ra_k ≥ DEPTH.
  - Reads 0 when ZERO_REG=1 and ra_k = 0.
- Write eligibility: port X writes on a rising edge when we_x=1, wa_x < DEPTH, and not (ZERO_REG=1 and wa_x=0). An ineligible write has no effect.
- Simultaneous eligible writes to different addresses: both take effect on the same edge.
- Simultaneous eligible writes to the same address (collision):
  - Port B wins and wd_b is stored.
  - wr_conflict is set to 1 on that edge.
  - Any other edge clears wr_conflict to 0, so it is a one-cycle pulse per colliding edge.
- Collision detection uses eligible writes only. Two writes to register 0 with ZERO_REG=1 do not raise wr_conflict.
- Reset (rst=1, at any time, including mid-write): every register clears to 0 immediately and wr_conflict clears to 0. While rst is held, writes are ignored.
- After rst deasserts, the first rising edge accepts writes normally.
- All read ports are independent. Any number of them may address the same register.

## Timing
- Read latency: 0 cycles (combinational from ra and register state).
- Write latency: data is visible on rd in the cycle after the writing edge, or in the same cycle when BYPASS_EN is defined.
- wr_conflict is valid 1 cycle after the colliding edge and lasts exactly 1 cycle.
- Reset values: all registers 0; rd = 0 for every port; wr_conflict = 0.
- No handshake. Writes are single-cycle and unconditional when eligible.

## Configuration
- Macro: BR_MULTIPORT_BYPASS_EN.
- Defined: write-first forwarding.
  - A read port whose address matches an eligible write in the current cycle returns that write's data combinationally, before the edge.
  - If both ports match, wd_b wins, consistent with the collision rule.
  - Register 0 with ZERO_REG=1 still reads 0.
- Undefined: read-before-write. rd shows the pre-edge register contents and there is no combinational path from wd_a/wd_b to rd.

## Test plan
- Reset: assert rst mid-cycle after writing reg 5 = 123 → rd for ra=5 reads 0 immediately; wr_conflict = 0.
- Basic write/read, NR=2:
  - Stimulus: we_a=1, wa_a=3, wd_a=123; then we_b=1, wa_b=4, wd_b=456.
  - Response: ra={4,3} reads rd={456,123} after the respective edges.
  - Register 2 remains 0.
- Dual-port writes:
  - Different addresses: wa_a=7 with 0xAAAA and wa_b=8 with 0x5555 on one edge → both stored; wr_conflict stays 0.
  - Same address: both ports write address 9 (A=1, B=2) → reg 9 = 2; wr_conflict = 1 for exactly one cycle.
- Zero register and range:
  - ZERO_REG=1: both ports write address 0 → rd for ra=0 reads 0; no conflict.
  - DEPTH=24: a write to address 30 has no effect, and ra=30 reads 0.
- Bypass:
  - Setup: reg 6 = 10, then we_a=1, wa_a=6, wd_a=77, with ra=6.
  - With BR_MULTIPORT_BYPASS_EN: rd = 77 before the edge.
  - Without it: rd = 10 before the edge and 77 after.
  - Repeat with both ports writing address 6 → bypass returns wd_b.

Source files
------------

// File: rtl/br_multiport.sv
// rtl/br_multiport.sv - multi-read, dual-write register bank with B-wins collision flag
// Optional write-first forwarding to the read ports: define BR_MULTIPORT_BYPASS_EN.
module br_multiport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NR*AW-1:0]    ra,
  output logic [NR*WIDTH-1:0] rd,
  input  logic                we_a,
  input  logic [AW-1:0]       wa_a,
  input  logic [WIDTH-1:0]    wd_a,
  input  logic                we_b,
  input  logic [AW-1:0]       wa_b,
  input  logic [WIDTH-1:0]    wd_b,
  output logic                wr_conflict
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             wr_conflict_q;
  logic             wr_conflict_d;
  logic             elig_a;
  logic             elig_b;

  // True for addresses that hold real, writable storage.
  function automatic logic addressable(input logic [AW-1:0] addr);
    return ({1'b0, addr} < DEPTH_W) && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  function automatic logic [WIDTH-1:0] read_word(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] data;
    data = '0;
    if (addressable(addr)) data = regs_q[addr];
`ifdef BR_MULTIPORT_BYPASS_EN
    if (elig_a && (wa_a == addr)) data = wd_a;
    if (elig_b && (wa_b == addr)) data = wd_b;
`endif
    return data;
  endfunction

  // Gating with rst keeps writes (and any forwarding) dead while reset is held.
  assign elig_a        = we_a && !rst && addressable(wa_a);
  assign elig_b        = we_b && !rst && addressable(wa_b);
  assign wr_conflict_d = elig_a && elig_b && (wa_a == wa_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      if (elig_a) regs_q[wa_a] <= wd_a;
      // Port B is applied last so it wins a same-address collision.
      if (elig_b) regs_q[wa_b] <= wd_b;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  always_comb begin
    rd = '0;
    for (int k = 0; k < NR; k++) begin
      rd[k*WIDTH +: WIDTH] = read_word(ra[k*AW +: AW]);
    end
  end

  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_br_multiport.sv
// tb/tb_br_multiport.sv - directed self-checking bench for br_multiport
module tb_br_multiport;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  ra = '0;
  logic [63:0] rd;
  logic [63:0] rd24;
  logic        we_a = 1'b0;
  logic [4:0]  wa_a = '0;
  logic [31:0] wd_a = '0;
  logic        we_b = 1'b0;
  logic [4:0]  wa_b = '0;
  logic [31:0] wd_b = '0;
  logic        wr_conflict;
  logic        wr_conflict24;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  br_multiport dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .wr_conflict(wr_conflict)
  );

  br_multiport #(.DEPTH(24)) dut24 (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd24),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .wr_conflict(wr_conflict24)
  );

  task automatic idle_writes();
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (rd !== 64'd0) $display("FAIL reset_rd got %h exp 0", rd); else passed++;
    total++; if (wr_conflict !== 1'b0) $display("FAIL reset_conflict got %b exp 0", wr_conflict); else passed++;
    total++; if (rd24 !== 64'd0) $display("FAIL reset_rd24 got %h exp 0", rd24); else passed++;
    @(negedge clk);
    rst = 1'b0;
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'd123;
    @(negedge clk);
    idle_writes();
    ra = {5'd0, 5'd5};
    #1;
    total++; if (rd[31:0] !== 32'd123) $display("FAIL pre_reset_r5 got %0d exp 123", rd[31:0]); else passed++;
    rst = 1'b1;
    #1;
    total++; if (rd[31:0] !== 32'd0) $display("FAIL async_reset_r5 got %0d exp 0", rd[31:0]); else passed++;
    total++; if (wr_conflict !== 1'b0) $display("FAIL async_reset_conflict got %b exp 0", wr_conflict); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    we_a = 1'b1; wa_a = 5'd3; wd_a = 32'd123;
    ra = {5'd4, 5'd3};
    @(negedge clk);
    we_a = 1'b0;
    we_b = 1'b1; wa_b = 5'd4; wd_b = 32'd456;
    #1;
    total++; if (rd[31:0] !== 32'd123) $display("FAIL basic_r3 got %0d exp 123", rd[31:0]); else passed++;
    @(negedge clk);
    idle_writes();
    #1;
    total++; if (rd !== {32'd456, 32'd123}) $display("FAIL basic_r4_r3 got %h exp %h", rd, {32'd456, 32'd123}); else passed++;
    ra = {5'd2, 5'd2};
    #1;
    total++; if (rd !== 64'd0) $display("FAIL basic_r2 got %h exp 0", rd); else passed++;
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    we_a = 1'b1; wa_a = 5'd7; wd_a = 32'hAAAA;
    we_b = 1'b1; wa_b = 5'd8; wd_b = 32'h5555;
    @(negedge clk);
    idle_writes();
    ra = {5'd8, 5'd7};
    #1;
    total++; if (rd !== {32'h5555, 32'hAAAA}) $display("FAIL dual_diff got %h exp %h", rd, {32'h5555, 32'hAAAA}); else passed++;
    total++; if (wr_conflict !== 1'b0) $display("FAIL dual_diff_conflict got %b exp 0", wr_conflict); else passed++;
    we_a = 1'b1; wa_a = 5'd9; wd_a = 32'd1;
    we_b = 1'b1; wa_b = 5'd9; wd_b = 32'd2;
    @(negedge clk);
    idle_writes();
    ra = {5'd0, 5'd9};
    #1;
    total++; if (rd[31:0] !== 32'd2) $display("FAIL collide_r9 got %0d exp 2", rd[31:0]); else passed++;
    total++; if (wr_conflict !== 1'b1) $display("FAIL collide_flag got %b exp 1", wr_conflict); else passed++;
    @(negedge clk);
    #1;
    total++; if (wr_conflict !== 1'b0) $display("FAIL collide_pulse_end got %b exp 0", wr_conflict); else passed++;
  endtask

  task automatic test_zero_and_range();
    @(negedge clk);
    we_a = 1'b1; wa_a = 5'd0; wd_a = 32'd11;
    we_b = 1'b1; wa_b = 5'd0; wd_b = 32'd22;
    @(negedge clk);
    idle_writes();
    ra = {5'd0, 5'd0};
    #1;
    total++; if (rd !== 64'd0) $display("FAIL zero_reg got %h exp 0", rd); else passed++;
    total++; if (wr_conflict !== 1'b0) $display("FAIL zero_conflict got %b exp 0", wr_conflict); else passed++;
    we_a = 1'b1; wa_a = 5'd30; wd_a = 32'h1234;
    we_b = 1'b1; wa_b = 5'd23; wd_b = 32'h77;
    @(negedge clk);
    idle_writes();
    ra = {5'd23, 5'd30};
    #1;
    total++; if (rd24[31:0] !== 32'd0) $display("FAIL range24_r30 got %h exp 0", rd24[31:0]); else passed++;
    total++; if (rd24[63:32] !== 32'h77) $display("FAIL range24_r23 got %h exp 77", rd24[63:32]); else passed++;
    total++; if (rd[31:0] !== 32'h1234) $display("FAIL range32_r30 got %h exp 1234", rd[31:0]); else passed++;
    we_a = 1'b1; wa_a = 5'd30; wd_a = 32'h1;
    we_b = 1'b1; wa_b = 5'd30; wd_b = 32'h2;
    @(negedge clk);
    idle_writes();
    #1;
    total++; if (wr_conflict24 !== 1'b0) $display("FAIL range24_conflict got %b exp 0", wr_conflict24); else passed++;
    total++; if (wr_conflict !== 1'b1) $display("FAIL range32_conflict got %b exp 1", wr_conflict); else passed++;
    total++; if (rd24[31:0] !== 32'd0) $display("FAIL range24_r30_again got %h exp 0", rd24[31:0]); else passed++;
  endtask

  task automatic test_bypass();
    logic [31:0] exp_pre;
    @(negedge clk);
    we_a = 1'b1; wa_a = 5'd6; wd_a = 32'd10;
    @(negedge clk);
    we_a = 1'b1; wa_a = 5'd6; wd_a = 32'd77;
    ra = {5'd0, 5'd6};
`ifdef BR_MULTIPORT_BYPASS_EN
    exp_pre = 32'd77;
`else
    exp_pre = 32'd10;
`endif
    #1;
    total++; if (rd[31:0] !== exp_pre) $display("FAIL bypass_a_pre got %0d exp %0d", rd[31:0], exp_pre); else passed++;
    @(negedge clk);
    idle_writes();
    #1;
    total++; if (rd[31:0] !== 32'd77) $display("FAIL bypass_a_post got %0d exp 77", rd[31:0]); else passed++;
    we_a = 1'b1; wa_a = 5'd6; wd_a = 32'd88;
    we_b = 1'b1; wa_b = 5'd6; wd_b = 32'd99;
`ifdef BR_MULTIPORT_BYPASS_EN
    exp_pre = 32'd99;
`else
    exp_pre = 32'd77;
`endif
    #1;
    total++; if (rd[31:0] !== exp_pre) $display("FAIL bypass_ab_pre got %0d exp %0d", rd[31:0], exp_pre); else passed++;
    @(negedge clk);
    idle_writes();
    #1;
    total++; if (rd[31:0] !== 32'd99) $display("FAIL bypass_ab_post got %0d exp 99", rd[31:0]); else passed++;
    total++; if (wr_conflict !== 1'b1) $display("FAIL bypass_ab_conflict got %b exp 1", wr_conflict); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dual_write();
    test_zero_and_range();
    test_bypass();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
